// File: rtl/ttt_move_engine.sv
// ttt_move_engine: sequential CPU move selector for an N x N tic-tac-toe board.
//   easy   : first empty cell from index 0
//   medium : take a winning cell if one exists, else first empty cell
//            circularly from an LFSR-chosen start cell
//   hard   : win, else block, else centre (odd N), else first empty from 0
// Ports:
//   clock, reset_n       system clock (rising edge), async active-low reset
//   start                request a move (accepted in IDLE only)
//   difficulty[1:0]      0 easy, 1 medium, 2/3 hard (sampled at accept)
//   board[2*CELLS-1:0]   cell i at [2i+1:2i]: 0 player, 1 CPU, 2 empty, 3 blocked
//   busy                 request in progress (through the done cycle)
//   done                 one-cycle result strobe
//   no_move              with done: no empty cell on the board
//   move_idx/row/col     chosen cell, held until the next done
module ttt_move_engine #(
  parameter int          N     = 3,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int         CELLS = N*N,
  localparam int         IW    = $clog2(CELLS),
  localparam int         RW    = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           difficulty,
  input  logic [2*CELLS-1:0]   board,
  output logic                 busy,
  output logic                 done,
  output logic                 no_move,
  output logic [IW-1:0]        move_idx,
  output logic [RW-1:0]        move_row,
  output logic [RW-1:0]        move_col
);

  localparam int NLINES = 2*N + 2;
  localparam int LW     = $clog2(NLINES);
  localparam int CTR    = (N/2)*N + N/2;

  localparam logic [1:0] C_PLY = 2'd0;
  localparam logic [1:0] C_CPU = 2'd1;
  localparam logic [1:0] C_EMP = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_LINES, S_DECIDE, S_SCAN, S_DONE} state_t;
  state_t state, state_n;

  logic [CELLS-1:0][1:0] brd;
  logic                  hard;
  logic [15:0]           lfsr;
  logic [IW-1:0]         s_ptr, s_start;
  logic [LW-1:0]         line_ptr;
  logic [IW-1:0]         scan_ptr, scan_cnt;
  logic                  blk_vld;
  logic [IW-1:0]         blk_idx;

  // cell indices of the line currently under examination
  logic [IW-1:0] lc [N];
  logic [3:0]    n_cpu, n_ply, n_emp;
  logic [IW-1:0] emp_idx;
  logic          win, blk;

  logic          fin, fin_none;
  logic [IW-1:0] fin_idx;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // LFSR low bits folded into [0, CELLS); 2^IW < 2*CELLS so one subtract is enough
  always_comb begin
    if (int'(lfsr[IW-1:0]) >= CELLS) s_start = IW'(int'(lfsr[IW-1:0]) - CELLS);
    else                             s_start = lfsr[IW-1:0];
  end

  // line order: rows, columns, main diagonal, anti-diagonal
  always_comb begin
    for (int p = 0; p < N; p++) begin
      if (int'(line_ptr) < N)        lc[p] = IW'(int'(line_ptr)*N + p);
      else if (int'(line_ptr) < 2*N) lc[p] = IW'(p*N + int'(line_ptr) - N);
      else if (int'(line_ptr) == 2*N) lc[p] = IW'(p*N + p);
      else                            lc[p] = IW'(p*N + N - 1 - p);
    end
  end

  // descending walk so the surviving emp_idx is the lowest-position empty cell
  always_comb begin
    n_cpu   = '0;
    n_ply   = '0;
    n_emp   = '0;
    emp_idx = '0;
    for (int p = N-1; p >= 0; p--) begin
      case (brd[lc[p]])
        C_PLY:   n_ply = n_ply + 4'd1;
        C_CPU:   n_cpu = n_cpu + 4'd1;
        C_EMP: begin
          n_emp   = n_emp + 4'd1;
          emp_idx = lc[p];
        end
        default: ;
      endcase
    end
  end

  assign win = (n_cpu == 4'(N-1)) && (n_emp == 4'd1);
  assign blk = (n_ply == 4'(N-1)) && (n_emp == 4'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fin      = 1'b0;
    fin_none = 1'b0;
    fin_idx  = '0;
    case (state)
      S_IDLE:
        if (start) state_n = (difficulty == 2'd0) ? S_SCAN : S_LINES;
      S_LINES:
        if (win) begin
          fin     = 1'b1;
          fin_idx = emp_idx;
        end else if (line_ptr == LW'(NLINES-1)) begin
          state_n = S_DECIDE;
        end
      S_DECIDE:
        if (hard && blk_vld) begin
          fin     = 1'b1;
          fin_idx = blk_idx;
        end else if (hard && (N % 2 == 1) && brd[CTR] == C_EMP) begin
          fin     = 1'b1;
          fin_idx = IW'(CTR);
        end else begin
          state_n = S_SCAN;
        end
      S_SCAN:
        if (brd[scan_ptr] == C_EMP) begin
          fin     = 1'b1;
          fin_idx = scan_ptr;
        end else if (scan_cnt == IW'(CELLS-1)) begin
          fin      = 1'b1;
          fin_none = 1'b1;
        end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (fin) state_n = S_DONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr     <= SEED;
      brd      <= '0;
      hard     <= 1'b0;
      s_ptr    <= '0;
      line_ptr <= '0;
      scan_ptr <= '0;
      scan_cnt <= '0;
      blk_vld  <= 1'b0;
      blk_idx  <= '0;
      no_move  <= 1'b0;
      move_idx <= '0;
      move_row <= '0;
      move_col <= '0;
    end else begin
      // Galois, x^16+x^14+x^13+x^11+1, free-running
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

      case (state)
        S_IDLE:
          if (start) begin
            brd      <= board;
            hard     <= difficulty[1];
            s_ptr    <= s_start;
            line_ptr <= '0;
            scan_ptr <= '0;
            scan_cnt <= '0;
            blk_vld  <= 1'b0;
            blk_idx  <= '0;
          end
        S_LINES: begin
          line_ptr <= line_ptr + 1'b1;
          if (hard && blk && !blk_vld) begin
            blk_vld <= 1'b1;
            blk_idx <= emp_idx;
          end
        end
        S_DECIDE: begin
          scan_ptr <= hard ? '0 : s_ptr;
          scan_cnt <= '0;
        end
        S_SCAN: begin
          scan_ptr <= (scan_ptr == IW'(CELLS-1)) ? '0 : scan_ptr + 1'b1;
          scan_cnt <= scan_cnt + 1'b1;
        end
        default: ;
      endcase

      if (fin) begin
        move_idx <= fin_idx;
        move_row <= RW'(int'(fin_idx) / N);
        move_col <= RW'(int'(fin_idx) % N);
        no_move  <= fin_none;
      end
    end
  end

endmodule

// File: tb/tb_ttt_move_engine.sv
// Directed bench for ttt_move_engine (N=3 main instance, N=4 for the even-N
// centre case) plus a 1000-board medium sweep against a reference LFSR.
module tb_ttt_move_engine;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic             start3 = 1'b0;
  logic [1:0]       diff3  = '0;
  logic [17:0]      board3 = '0;
  logic             busy3, done3, nomv3;
  logic [3:0]       idx3;
  logic [1:0]       row3, col3;

  logic             start4 = 1'b0;
  logic [1:0]       diff4  = '0;
  logic [31:0]      board4 = '0;
  logic             busy4, done4, nomv4;
  logic [3:0]       idx4;
  logic [1:0]       row4, col4;

  ttt_move_engine #(.N(3), .SEED(16'hACE1)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3), .difficulty(diff3),
    .board(board3), .busy(busy3), .done(done3), .no_move(nomv3),
    .move_idx(idx3), .move_row(row3), .move_col(col3));

  ttt_move_engine #(.N(4), .SEED(16'hACE1)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .difficulty(diff4),
    .board(board4), .busy(busy4), .done(done4), .no_move(nomv4),
    .move_idx(idx4), .move_row(row4), .move_col(col4));

  // reference LFSR
  logic [15:0] m_lfsr;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // issue one N=3 request; returns done cycle (accept = 0) and LFSR at accept
  task automatic req(input logic [17:0] b, input logic [1:0] d,
                     output int cyc, output logic [15:0] lf);
    @(negedge clock);
    board3 = b; diff3 = d; start3 = 1'b1; lf = m_lfsr;
    @(posedge clock);
    #1 start3 = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (done3) begin cyc = c; break; end
    end
    if (cyc < 0) chk("timeout", cyc, 0);
  endtask

  int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  initial begin
    logic [8:0][1:0] b;
    logic [15:0]     lf;
    int              cyc, s, d, ex, ne, nc;
    bit              ok;

    repeat (3) @(posedge clock);
    #1;
    chk("rst busy", busy3, 0);
    chk("rst done", done3, 0);
    chk("rst idx", idx3, 0);
    chk("rst nomv", nomv3, 0);
    @(negedge clock) reset_n = 1'b1;

    // easy: 0,1 player -> cell 2 at cycle 4
    b = {9{2'b10}}; b[0] = 2'd0; b[1] = 2'd0;
    req(b, 2'd0, cyc, lf);
    chk("easy cyc", cyc, 4);
    chk("easy idx", idx3, 2);
    chk("easy row", row3, 0);
    chk("easy col", col3, 2);
    chk("easy nomv", nomv3, 0);

    // hard win on row 0
    b = {9{2'b10}}; b[0] = 2'd1; b[1] = 2'd1; b[3] = 2'd0; b[4] = 2'd0;
    req(b, 2'd2, cyc, lf);
    chk("win cyc", cyc, 2);
    chk("win idx", idx3, 2);

    // hard block on main diagonal
    b = {9{2'b10}}; b[0] = 2'd0; b[4] = 2'd0; b[1] = 2'd1;
    req(b, 2'd2, cyc, lf);
    chk("blk cyc", cyc, 10);
    chk("blk idx", idx3, 8);
    chk("blk row", row3, 2);
    chk("blk col", col3, 2);

    // hard centre
    b = {9{2'b10}};
    req(b, 2'd3, cyc, lf);
    chk("ctr cyc", cyc, 10);
    chk("ctr idx", idx3, 4);
    chk("ctr row", row3, 1);

    // N=4 hard all empty -> fallback scan, cell 0 at cycle 13
    @(negedge clock);
    board4 = {16{2'b10}}; diff4 = 2'd2; start4 = 1'b1;
    @(posedge clock);
    #1 start4 = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (done4) begin cyc = c; break; end
    end
    chk("n4 cyc", cyc, 13);
    chk("n4 idx", idx4, 0);
    chk("n4 nomv", nomv4, 0);

    // full board with one blocked cell
    b[0] = 2'd0; b[1] = 2'd1; b[2] = 2'd0; b[3] = 2'd1; b[4] = 2'd0;
    b[5] = 2'd1; b[6] = 2'd1; b[7] = 2'd0; b[8] = 2'd3;
    req(b, 2'd0, cyc, lf);
    chk("full easy cyc", cyc, 10);
    chk("full easy nomv", nomv3, 1);
    chk("full easy idx", idx3, 0);
    req(b, 2'd2, cyc, lf);
    chk("full hard cyc", cyc, 19);
    chk("full hard nomv", nomv3, 1);

    // start held through busy and DONE; board changed mid-request
    b = {9{2'b10}}; b[0] = 2'd0; b[4] = 2'd0; b[1] = 2'd1;
    @(negedge clock);
    board3 = b; diff3 = 2'd2; start3 = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clock);
      if (c == 1)  chk("hold busy1", busy3, 1);
      if (c == 3)  board3 = {9{2'b10}};
      if (c == 10) begin
        chk("hold done", done3, 1);
        chk("hold idx", idx3, 8);
      end
      if (c == 11) chk("hold idle", busy3, 0);
      if (c == 12) begin
        chk("hold reaccept", busy3, 1);
        start3 = 1'b0;
      end
      if (c == 21) begin
        chk("hold done2", done3, 1);
        chk("hold idx2", idx3, 4);
      end
    end

    // reset mid-LINES
    @(negedge clock);
    board3 = {9{2'b10}}; diff3 = 2'd2; start3 = 1'b1;
    @(posedge clock);
    #1 start3 = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rl busy", busy3, 0);
    chk("rl idx", idx3, 0);
    chk("rl row", row3, 0);
    chk("rl col", col3, 0);
    @(negedge clock) reset_n = 1'b1;

    b = {9{2'b10}}; b[0] = 2'd0; b[1] = 2'd0;
    req(b, 2'd0, cyc, lf);
    chk("post rl cyc", cyc, 4);
    chk("post rl idx", idx3, 2);

    // reset mid-SCAN
    b = {9{2'b01}};
    @(negedge clock);
    board3 = b; diff3 = 2'd0; start3 = 1'b1;
    @(posedge clock);
    #1 start3 = 1'b0;
    repeat (5) @(negedge clock);
    chk("rs busy pre", busy3, 1);
    reset_n = 1'b0;
    #1;
    chk("rs busy", busy3, 0);
    chk("rs done", done3, 0);
    chk("rs idx", idx3, 0);
    chk("rs col", col3, 0);
    @(negedge clock) reset_n = 1'b1;

    b = {9{2'b10}}; b[0] = 2'd1; b[1] = 2'd1; b[3] = 2'd0; b[4] = 2'd0;
    req(b, 2'd2, cyc, lf);
    chk("post rs cyc", cyc, 2);
    chk("post rs idx", idx3, 2);

    // medium sweep: not full, no CPU win available
    for (int t = 0; t < 1000; t++) begin
      ok = 1'b0;
      for (int a = 0; a < 1000 && !ok; a++) begin
        for (int i = 0; i < 9; i++) b[i] = 2'($urandom_range(0, 3));
        ok = 1'b0;
        for (int i = 0; i < 9; i++) if (b[i] == 2'd2) ok = 1'b1;
        for (int l = 0; l < 8; l++) begin
          ne = 0; nc = 0;
          for (int p = 0; p < 3; p++) begin
            if (b[ln[l][p]] == 2'd2) ne++;
            if (b[ln[l][p]] == 2'd1) nc++;
          end
          if (ne == 1 && nc == 2) ok = 1'b0;
        end
      end
      req(b, 2'd1, cyc, lf);
      s = int'(lf[3:0]);
      if (s >= 9) s = s - 9;
      d = 0;
      while (b[(s + d) % 9] != 2'd2) d++;
      ex = (s + d) % 9;
      chk("med idx", idx3, ex);
      chk("med cyc", cyc, 11 + d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
